div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Run-time controller for the counter-based clock divider.
- Sequences divider start and stop, and accepts new divide ratios through a valid/ready handshake.
- Applies a new ratio only at a period boundary, so clk_div never produces a runt pulse.
- Emits the divided clock plus a one-cycle tick that downstream logic uses as a clock enable.

Parameters:
- CNT_W, 8: width of the ratio and internal counter.
- DEF_DIV, 4: divide ratio loaded at reset. Must be even and >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request. Level sensitive.
- cfg_div  in  CNT_W  requested divide ratio N.
- cfg_valid  in  1  cfg_div valid.
- cfg_ready  out  1  controller can accept cfg_div.
- cfg_err  out  1  one-cycle pulse when an illegal ratio is presented.
- clk_div  out  1  divided clock. Registered.
- tick  out  1  one-cycle pulse in the cycle clk_div rises.
- busy  out  1  high in RUN, PEND and STOP.
- cur_div  out  CNT_W  ratio currently in effect.

Behaviour:
- Reset values: cnt=0, clk_div=0, tick=0, cfg_err=0, busy=0, cur_div=DEF_DIV, state=IDLE, cfg_ready=1.
- States:
  - IDLE: cnt and clk_div held at 0.
  - RUN: divider running.
  - PEND: new ratio held in a shadow register, waiting for the period boundary.
  - STOP: finishing the current period after en falls.
- Counter: cnt increments each cycle in RUN, PEND and STOP. It wraps to 0 when cnt==cur_div-1; this cycle is the "wrap".
- clk_div: goes 1 on the edge after cnt==H-1, with H = cur_div/2. It goes 0 on the edge after the wrap.
- Duty cycle: low for H cycles, then high for H cycles. For N=4 after en rises, clk_div reads 0,0,1,1,0,0,1,1...
- tick: 1 exactly in the cycles where clk_div transitions 0->1.
- Handshake: a transfer occurs when cfg_valid && cfg_ready. cfg_ready=1 in IDLE and RUN, 0 in PEND and STOP.
- Ratio legality: legal ratio means even and >= 2. An illegal ratio is still consumed (handshake completes), cfg_err pulses for 1 cycle in the following cycle, and cur_div is unchanged.
- Transitions:
  - IDLE, legal transfer: cur_div updated on the next edge.
  - IDLE, en=1: go to RUN. A cfg transfer in the same cycle as en rising applies to the first period.
  - RUN, legal transfer: capture into shadow, go to PEND.
  - RUN, en=0: go to STOP.
  - PEND, at wrap: cur_div <= shadow, go to RUN. The new period starts with cnt=0 under the new ratio.
  - PEND, en=0: go to STOP. The shadow is kept and still applied at the wrap.
  - STOP, at wrap: apply any pending shadow, clk_div=0, go to IDLE.
  - STOP, en re-asserted before wrap: return to RUN, or to PEND if a shadow is held. The period is not interrupted.
- Timing: new-ratio latency in RUN is at most old cur_div cycles after the transfer.
- Reset mid-operation: immediate return to the reset values. A held shadow is discarded.
- Width: cnt is CNT_W bits. Compares are unsigned, and H is cur_div>>1.

Optional Feature:
- Macro: DIV_SCHED_ODD_EN.
- Defined: odd ratios >= 3 are legal. Low phase is ceil(N/2) cycles and high phase is floor(N/2) cycles; rise occurs on the edge after cnt==ceil(N/2)-1. N=1 still raises cfg_err.
- Undefined: odd ratios raise cfg_err as specified above.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, RUN, PEND, STOP);
  - the default-ratio constant;
  - a legality function is_legal_div(N).
- One sub-module, div_core: counter plus clk_div/tick generation from cur_div and a run enable.
- div_sched itself holds the FSM, the shadow register and the handshake.

Test Plan:
- Reset, then en=1 with DEF_DIV=4 -> clk_div period 4 with 2 cycles high, tick every 4 cycles, busy=1, cur_div=4.
- In RUN, send cfg_div=8 mid-period -> cfg_ready drops, old period completes at N=4, then period 8 (4 low/4 high), cur_div=8, cfg_ready=1.
- Send cfg_div=5 and cfg_div=0 (macro undefined) -> each produces one cfg_err pulse, cur_div unchanged, no clock glitch. With DIV_SCHED_ODD_EN, 5 gives 3 low/2 high.
- Drop en mid-period at N=6 -> the period completes, clk_div=0, then IDLE with busy=0. Re-raising en before the wrap continues without a gap.
- In IDLE, send cfg_div=2 in the same cycle en rises -> first period is 1 low/1 high and tick alternates.
- Assert rst during PEND -> all outputs return to reset values, cur_div=4, pending ratio discarded.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: controller state enum, default divide ratio, ratio legality and
// low-phase helpers. The DIV_SCHED_ODD_EN macro enables odd divide ratios.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int DEF_DIV_RATIO = 4;

  // A ratio is legal when the divider can produce at least one cycle of
  // each phase: even ratios >= 2, plus odd ratios >= 3 when odd support is on.
  function automatic logic is_legal_div(input logic [31:0] n);
`ifdef DIV_SCHED_ODD_EN
    return (n >= 32'd2);
`else
    return (n >= 32'd2) && !n[0];
`endif
  endfunction

  // Length of the low phase: ceil(n/2). Equals n/2 for even ratios, so the
  // same formula serves both builds.
  function automatic logic [31:0] low_phase(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/div_core.sv
// Counter-based divider: free-running count with clk_div/tick generation.
// Latency: clk_div and tick are registered, one cycle after the count match.
// Backpressure: none; runs every cycle while run=1, held cleared otherwise.
// Ports: clk, rst (async, active-high), run (count enable), cur_div (ratio),
//        clk_div (divided clock), tick (rise strobe), wrap (last count of period).
module div_core
  import div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] cur_div,
  output logic             clk_div,
  output logic             tick,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lo_len;
  logic             rise;

  assign lo_len = CNT_W'(low_phase(32'(cur_div)));
  assign wrap   = run && (cnt == (cur_div - CNT_W'(1)));
  // Last cycle of the low phase; clk_div goes high on the following edge.
  assign rise   = run && (cnt == (lo_len - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + CNT_W'(1);
      tick <= rise;
      // rise and wrap never coincide for legal ratios (low phase >= 1,
      // high phase >= 1), so the order here only matters for illegal ones.
      if (rise) begin
        clk_div <= 1'b1;
      end else if (wrap) begin
        clk_div <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// Run-time controller for the counter-based divider: start/stop sequencing and
// glitch-free ratio updates. Latency: a new ratio takes effect at the next
// period boundary (at most old cur_div cycles). Backpressure: cfg_ready is low
// while a ratio is pending (PEND) or the divider is finishing a period (STOP).
// Ports: clk, rst (async, active-high), en (run request), cfg_div/cfg_valid/
//        cfg_ready (ratio handshake), cfg_err (illegal-ratio pulse), clk_div,
//        tick, busy, cur_div. DIV_SCHED_ODD_EN enables odd divide ratios.
module div_sched
  import div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = DEF_DIV_RATIO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] shadow, shadow_nx;
  logic [CNT_W-1:0] cur_div_nx;
  logic             shadow_vld, shadow_vld_nx;
  logic             cfg_err_nx;
  logic             xfer;
  logic             legal;
  logic             wrap;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign busy      = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = is_legal_div(32'(cfg_div));

  div_core #(.CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (busy),
    .cur_div (cur_div),
    .clk_div (clk_div),
    .tick    (tick),
    .wrap    (wrap)
  );

  always_comb begin
    state_nx      = state;
    cur_div_nx    = cur_div;
    shadow_nx     = shadow;
    shadow_vld_nx = shadow_vld;
    // Illegal ratios are still consumed; only the error strobe records them.
    cfg_err_nx    = xfer && !legal;

    case (state)
      IDLE: begin
        // Divider is stopped, so a new ratio can be applied directly and
        // governs the first period if en rises in the same cycle.
        if (xfer && legal) begin
          cur_div_nx = cfg_div;
        end
        if (en) begin
          state_nx = RUN;
        end
      end

      RUN: begin
        if (xfer && legal) begin
          if (wrap) begin
            // This cycle is already the period boundary.
            cur_div_nx = cfg_div;
          end else begin
            shadow_nx     = cfg_div;
            shadow_vld_nx = 1'b1;
          end
        end
        if (!en) begin
          state_nx = STOP;
        end else if (xfer && legal && !wrap) begin
          state_nx = PEND;
        end
      end

      PEND: begin
        if (wrap) begin
          cur_div_nx    = shadow;
          shadow_vld_nx = 1'b0;
          state_nx      = en ? RUN : STOP;
        end else if (!en) begin
          state_nx = STOP;
        end
      end

      STOP: begin
        if (wrap) begin
          if (shadow_vld) begin
            cur_div_nx    = shadow;
            shadow_vld_nx = 1'b0;
          end
          // en back high exactly at the boundary continues without a gap.
          state_nx = en ? RUN : IDLE;
        end else if (en) begin
          state_nx = shadow_vld ? PEND : RUN;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_div    <= CNT_W'(DEF_DIV);
      shadow     <= '0;
      shadow_vld <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cur_div    <= cur_div_nx;
      shadow     <= shadow_nx;
      shadow_vld <= shadow_vld_nx;
      cfg_err    <= cfg_err_nx;
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: expected clk_div/tick waveforms are
// queued from the ratio being exercised and popped once per clock.
// Inputs change 1ns after the rising edge; outputs are sampled at that point.
module tb_div_sched;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_div;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_div;

  typedef struct packed {
    logic clk_div;
    logic tick;
  } wav_t;

  wav_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  div_sched #(.CNT_W(CNT_W), .DEF_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_div   (clk_div),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue `reps` periods of ratio n: ceil(n/2) low, floor(n/2) high, tick on
  // the first high cycle.
  function automatic void push_period(input int n, input int reps);
    wav_t w;
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < n - n / 2; k++) begin
        w.clk_div = 1'b0;
        w.tick    = 1'b0;
        exp_q.push_back(w);
      end
      for (int k = 0; k < n / 2; k++) begin
        w.clk_div = 1'b1;
        w.tick    = (k == 0);
        exp_q.push_back(w);
      end
    end
  endfunction

  function automatic void push_high(input int cnt);
    wav_t w;
    w.clk_div = 1'b1;
    w.tick    = 1'b0;
    for (int k = 0; k < cnt; k++) exp_q.push_back(w);
  endfunction

  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (tick === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: no tick within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    cyc(); cyc();
    tests++;
    if ({clk_div, tick, cfg_err, busy, cfg_ready} !== 5'b00001) begin
      fails++;
      $display("FAIL reset_flags: {clk_div,tick,cfg_err,busy,cfg_ready}=%b, expected 00001",
               {clk_div, tick, cfg_err, busy, cfg_ready});
    end
    tests++;
    if (cur_div !== 8'd4) begin
      fails++;
      $display("FAIL reset_cur_div: got %0d, expected 4", cur_div);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_run_default();
    wav_t w;
    exp_q.delete();
    en = 1'b1;
    push_period(4, 3);
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick) begin
        fails++;
        $display("FAIL run4_wave[%0d]: clk_div=%b tick=%b, expected %b %b",
                 i, clk_div, tick, w.clk_div, w.tick);
      end
      tests++;
      if (busy !== 1'b1 || cur_div !== 8'd4) begin
        fails++;
        $display("FAIL run4_status[%0d]: busy=%b cur_div=%0d, expected 1 4", i, busy, cur_div);
      end
    end
  endtask

  task automatic test_reconfig();
    wav_t w;
    exp_q.delete();
    wait_tick("reconfig_align");
    cfg_div = 8'd8; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    tests++;
    if (cfg_ready !== 1'b0 || cur_div !== 8'd4 || clk_div !== 1'b1) begin
      fails++;
      $display("FAIL reconfig_pend: cfg_ready=%b cur_div=%0d clk_div=%b, expected 0 4 1",
               cfg_ready, cur_div, clk_div);
    end
    push_period(8, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick) begin
        fails++;
        $display("FAIL reconfig_wave[%0d]: clk_div=%b tick=%b, expected %b %b",
                 i, clk_div, tick, w.clk_div, w.tick);
      end
      tests++;
      if (cur_div !== 8'd8 || cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL reconfig_status[%0d]: cur_div=%0d cfg_ready=%b, expected 8 1",
                 i, cur_div, cfg_ready);
      end
    end
  endtask

  task automatic test_illegal();
    wav_t w;
    logic [CNT_W-1:0] bad1;
    logic exp_err;
`ifdef DIV_SCHED_ODD_EN
    bad1 = 8'd1;
`else
    bad1 = 8'd5;
`endif
    exp_q.delete();
    wait_tick("illegal_align");
    push_high(3);
    push_period(8, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      cfg_valid = (i == 0) || (i == 3);
      cfg_div   = (i == 0) ? bad1 : 8'd0;
      cyc();
      exp_err = (i == 0) || (i == 3);
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick) begin
        fails++;
        $display("FAIL illegal_wave[%0d]: clk_div=%b tick=%b, expected %b %b",
                 i, clk_div, tick, w.clk_div, w.tick);
      end
      tests++;
      if (cfg_err !== exp_err || cur_div !== 8'd8 || cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL illegal_err[%0d]: cfg_err=%b cur_div=%0d cfg_ready=%b, expected %b 8 1",
                 i, cfg_err, cur_div, cfg_ready, exp_err);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_stop();
    wav_t w;
    logic exp_busy;
    exp_q.delete();
    // Move to N=6 first.
    wait_tick("stop_align8");
    push_high(3);
    push_period(6, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      cfg_valid = (i == 0);
      cfg_div   = 8'd6;
      cyc();
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick) begin
        fails++;
        $display("FAIL to6_wave[%0d]: clk_div=%b tick=%b, expected %b %b",
                 i, clk_div, tick, w.clk_div, w.tick);
      end
    end
    cfg_valid = 1'b0;
    tests++;
    if (cur_div !== 8'd6) begin
      fails++;
      $display("FAIL to6_cur_div: got %0d, expected 6", cur_div);
    end
    // Drop en mid-period: finish the period, then go idle.
    wait_tick("stop_align6");
    en = 1'b0;
    push_high(2);
    push_period(2, 0);
    w.clk_div = 1'b0; w.tick = 1'b0;
    exp_q.push_back(w); exp_q.push_back(w); exp_q.push_back(w);
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      exp_busy = (i < 2);
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick || busy !== exp_busy) begin
        fails++;
        $display("FAIL stop_wave[%0d]: clk_div=%b tick=%b busy=%b, expected %b %b %b",
                 i, clk_div, tick, busy, w.clk_div, w.tick, exp_busy);
      end
    end
    // Re-raise en before the wrap: the period continues without a gap.
    en = 1'b1;
    wait_tick("restart_align");
    push_high(2);
    push_period(6, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      en = (i != 0);
      cyc();
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick || busy !== 1'b1) begin
        fails++;
        $display("FAIL rearm_wave[%0d]: clk_div=%b tick=%b busy=%b, expected %b %b 1",
                 i, clk_div, tick, busy, w.clk_div, w.tick);
      end
      if (i == 0) begin
        tests++;
        if (cfg_ready !== 1'b0) begin
          fails++;
          $display("FAIL rearm_stop_ready: cfg_ready=%b, expected 0", cfg_ready);
        end
      end
    end
  endtask

  task automatic test_n2_same_cycle();
    wav_t w;
    bit idle_seen;
    exp_q.delete();
    en = 1'b0;
    idle_seen = 1'b0;
    for (int i = 0; i < 40 && !idle_seen; i++) begin
      cyc();
      if (busy === 1'b0) idle_seen = 1'b1;
    end
    tests++;
    if (!idle_seen) begin
      fails++;
      $display("FAIL n2_idle: busy still %b after 40 cycles, expected 0", busy);
    end
    push_period(2, 4);
    for (int i = 0; exp_q.size() > 0; i++) begin
      en        = 1'b1;
      cfg_valid = (i == 0);
      cfg_div   = 8'd2;
      cyc();
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick || cur_div !== 8'd2) begin
        fails++;
        $display("FAIL n2_wave[%0d]: clk_div=%b tick=%b cur_div=%0d, expected %b %b 2",
                 i, clk_div, tick, cur_div, w.clk_div, w.tick);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_pend();
    wav_t w;
    exp_q.delete();
    wait_tick("rstpend_align");
    cyc();
    cfg_div = 8'd8; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    tests++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rstpend_pend: cfg_ready=%b busy=%b, expected 0 1", cfg_ready, busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({clk_div, tick, cfg_err, busy, cfg_ready} !== 5'b00001 || cur_div !== 8'd4) begin
      fails++;
      $display("FAIL rstpend_async: flags=%b cur_div=%0d, expected 00001 4",
               {clk_div, tick, cfg_err, busy, cfg_ready}, cur_div);
    end
    cyc();
    rst = 1'b0;
    push_period(4, 3);
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick || cur_div !== 8'd4) begin
        fails++;
        $display("FAIL rstpend_wave[%0d]: clk_div=%b tick=%b cur_div=%0d, expected %b %b 4",
                 i, clk_div, tick, cur_div, w.clk_div, w.tick);
      end
    end
  endtask

`ifdef DIV_SCHED_ODD_EN
  task automatic test_odd();
    wav_t w;
    exp_q.delete();
    wait_tick("odd_align");
    push_high(1);
    push_period(5, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      cfg_valid = (i == 0);
      cfg_div   = 8'd5;
      cyc();
      w = exp_q.pop_front();
      tests++;
      if (clk_div !== w.clk_div || tick !== w.tick || cfg_err !== 1'b0) begin
        fails++;
        $display("FAIL odd5_wave[%0d]: clk_div=%b tick=%b cfg_err=%b, expected %b %b 0",
                 i, clk_div, tick, cfg_err, w.clk_div, w.tick);
      end
    end
    cfg_valid = 1'b0;
    tests++;
    if (cur_div !== 8'd5) begin
      fails++;
      $display("FAIL odd5_cur_div: got %0d, expected 5", cur_div);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run_default();
    test_reconfig();
    test_illegal();
    test_stop();
    test_n2_same_cycle();
    test_reset_pend();
`ifdef DIV_SCHED_ODD_EN
    test_odd();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
